// File: rtl/col_norm_sq_acc_if.sv
// Handshake bundle for the column-energy stage: element input stream
// towards the accumulator and column-sum output stream towards the sqrt unit.
interface col_norm_sq_acc_if #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 33,
    parameter int CIDX_W = 2
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_re;
    logic signed [DATA_W-1:0] in_im;
    logic                     out_valid;
    logic                     out_ready;
    logic [ACC_W-1:0]         out_sumsq;
    logic                     out_sat;
    logic [CIDX_W-1:0]        out_col_idx;
    logic                     out_last_col;

    // Producer of elements / consumer of column sums.
    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_sumsq, out_sat, out_col_idx, out_last_col
    );

    // The column-energy stage itself.
    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_sumsq, out_sat, out_col_idx, out_last_col
    );
endinterface

// File: rtl/col_norm_sq_acc.sv
// Streaming column energy: sums re^2 + im^2 over ROWS elements per column
// and hands the saturated sum to the square-root stage. One stall term
// (adv) freezes both pipeline stages while the output is held.
module col_norm_sq_acc #(
    parameter int DATA_W = 16,
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int ACC_W  = 33
) (
    input  logic             clk,
    input  logic             rst,
    col_norm_sq_acc_if.slave bus
);
    localparam int SQ_W   = 2 * DATA_W;
    localparam int RCNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CIDX_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [ACC_W-1:0]  ACC_MAX  = '1;
    localparam logic [RCNT_W-1:0] ROW_LAST = RCNT_W'(ROWS - 1);
    localparam logic [CIDX_W-1:0] COL_LAST = CIDX_W'(COLS - 1);

    // |x|^2 of one complex element; fits SQ_W unsigned bits even for the
    // (-2^(DATA_W-1), -2^(DATA_W-1)) corner, which gives exactly 2^(SQ_W-1).
    function automatic logic [SQ_W-1:0] cplx_energy(
        input logic signed [DATA_W-1:0] re,
        input logic signed [DATA_W-1:0] im
    );
        logic signed [SQ_W-1:0] re_x, im_x, re2, im2;
        re_x = $signed({{DATA_W{re[DATA_W-1]}}, re});
        im_x = $signed({{DATA_W{im[DATA_W-1]}}, im});
        re2  = re_x * re_x;
        im2  = im_x * im_x;
        return $unsigned(re2) + $unsigned(im2);
    endfunction

    // Saturating accumulate; returns {sat, value}. sat is sticky via sat_in.
    function automatic logic [ACC_W:0] sat_accum(
        input logic [ACC_W-1:0] acc,
        input logic [SQ_W-1:0]  sq,
        input logic             sat_in
    );
        logic [ACC_W:0] sum;
        sum = {1'b0, acc} + (ACC_W+1)'(sq);
        if (sum[ACC_W]) return {1'b1, ACC_MAX};
        return {sat_in, sum[ACC_W-1:0]};
    endfunction

    logic              adv;
    logic              accept;
    logic [RCNT_W-1:0] row_cnt_q;
    logic [CIDX_W-1:0] col_cnt_q;
    logic [SQ_W-1:0]   sq_p1_q;
    logic              vld_p1_q, first_p1_q, last_p1_q;
    logic [ACC_W-1:0]  acc_p2_q, acc_p2_d;
    logic              sat_p2_q, sat_p2_d;
    logic              out_valid_q, out_sat_q, out_last_q;
    logic [ACC_W-1:0]  out_sumsq_q;
    logic [CIDX_W-1:0] out_idx_q;

    assign adv          = !(out_valid_q && !bus.out_ready);
    assign accept       = bus.in_valid && adv;
    assign bus.in_ready = adv;

    // Stage 1: square the accepted element and tag its row position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt_q  <= '0;
            sq_p1_q    <= '0;
            vld_p1_q   <= 1'b0;
            first_p1_q <= 1'b0;
            last_p1_q  <= 1'b0;
        end else if (adv) begin
            vld_p1_q <= bus.in_valid;
            if (bus.in_valid) begin
                sq_p1_q    <= cplx_energy(bus.in_re, bus.in_im);
                first_p1_q <= (row_cnt_q == '0);
                last_p1_q  <= (row_cnt_q == ROW_LAST);
            end
            if (accept) row_cnt_q <= (row_cnt_q == ROW_LAST) ? '0 : row_cnt_q + 1'b1;
        end
    end

    // Stage 2 next state: row 0 restarts the column, others add with clamp.
    always_comb begin
        acc_p2_d = ACC_W'(sq_p1_q);
        sat_p2_d = 1'b0;
        if (!first_p1_q) {sat_p2_d, acc_p2_d} = sat_accum(acc_p2_q, sq_p1_q, sat_p2_q);
    end

    // Stage 2: column accumulator and sticky saturation flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_p2_q <= '0;
            sat_p2_q <= 1'b0;
        end else if (adv && vld_p1_q) begin
            acc_p2_q <= acc_p2_d;
            sat_p2_q <= sat_p2_d;
        end
    end

    // Output register: loads on a column's last row, otherwise drains on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sumsq_q <= '0;
            out_sat_q   <= 1'b0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            col_cnt_q   <= '0;
        end else if (adv && vld_p1_q && last_p1_q) begin
            out_valid_q <= 1'b1;
            out_sumsq_q <= acc_p2_d;
            out_sat_q   <= sat_p2_d;
            out_idx_q   <= col_cnt_q;
            out_last_q  <= (col_cnt_q == COL_LAST);
            col_cnt_q   <= (col_cnt_q == COL_LAST) ? '0 : col_cnt_q + 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_sumsq    = out_sumsq_q;
    assign bus.out_sat      = out_sat_q;
    assign bus.out_col_idx  = out_idx_q;
    assign bus.out_last_col = out_last_q;
endmodule
